// File: rtl/param_address_sequencer.sv
// Address sweep generator over [0, LIMIT] with all/even/odd strides, up/down, wrap or one-shot.
// One-cycle latency from EN/start to stored and flags; no backpressure, EN is a plain step enable.
module param_address_sequencer #(
    parameter int WIDTH = 15,
    parameter int LIMIT = 29399
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             EN,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             down,
    input  logic             one_shot,
    output logic [WIDTH-1:0] stored,
    output logic             wrapped,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    state_t           r_state;
    logic [1:0]       r_mode;
    logic             r_down;
    logic             r_one_shot;
    logic [WIDTH-1:0] r_stored;
    logic             r_wrapped;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_mode_in;
    logic [WIDTH-1:0] w_head_new;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_tail;
    logic [WIDTH-1:0] w_stride;
    logic [WIDTH-1:0] w_next;

    // Mode is normalised (11 -> 00) before latching so only three encodings remain.
    function automatic logic [WIDTH-1:0] f_first(input logic [1:0] m);
        return (m == 2'b10) ? WIDTH'(1) : '0;
    endfunction

    function automatic logic [WIDTH-1:0] f_last(input logic [1:0] m);
        case (m)
            2'b01:   return {LIM[WIDTH-1:1], 1'b0};
            2'b10:   return LIM[0] ? LIM : LIM - WIDTH'(1);
            default: return LIM;
        endcase
    endfunction

    assign w_mode_in  = (mode == 2'b11) ? 2'b00 : mode;
    assign w_head_new = down   ? f_last(w_mode_in) : f_first(w_mode_in);
    assign w_head     = r_down ? f_last(r_mode)    : f_first(r_mode);
    assign w_tail     = r_down ? f_first(r_mode)   : f_last(r_mode);
    assign w_stride   = (r_mode == 2'b00) ? WIDTH'(1) : WIDTH'(2);
    assign w_next     = r_down ? r_stored - w_stride : r_stored + w_stride;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state    <= S_IDLE;
            r_mode     <= 2'b00;
            r_down     <= 1'b0;
            r_one_shot <= 1'b0;
            r_stored   <= '0;
            r_wrapped  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wrapped <= 1'b0;
            if (start) begin
                r_mode     <= w_mode_in;
                r_down     <= down;
                r_one_shot <= one_shot;
                r_stored   <= w_head_new;
                r_state    <= S_RUN;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (EN) begin
                            if (r_stored == w_tail) begin
                                r_wrapped <= 1'b1;
                                // One-shot parks on the tail address; wrap mode restarts from head.
                                if (r_one_shot) begin
                                    r_state <= S_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_stored <= w_head;
                                end
                            end else begin
                                r_stored <= w_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stored  = r_stored;
    assign wrapped = r_wrapped;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
